// File: rtl/dac_pwm_driver.sv
// PWM DAC driver: a small sample FIFO feeds a duty register that is
// reloaded once per 2^N-cycle PWM period, with underrun reporting.
module dac_pwm_driver #(
  parameter  int N     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic [N-1:0]  sample_i,
  input  logic          sample_valid_i,
  output logic          sample_ready_o,
  input  logic          enable_i,
  output logic          pwm_o,
  output logic          period_tick_o,
  output logic          underrun_o,
  output logic [7:0]    underrun_cnt_o,
  output logic [CW-1:0] fifo_count_o
);

  localparam logic [N-1:0]  CNT_MAX = {N{1'b1}};
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [N-1:0]  r_cnt;
  logic [N-1:0]  r_duty;
  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_pwm;
  logic          r_underrun;
  logic [7:0]    r_urun_cnt;

  logic w_boundary;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_under;

  assign w_boundary = enable_i && (r_cnt == CNT_MAX);
  assign w_ready    = nRst || (r_count < FULL);
  assign w_push     = sample_valid_i && w_ready && !nRst;
  assign w_pop      = w_boundary && (r_count != '0);
  assign w_under    = w_boundary && (r_count == '0);

  assign sample_ready_o = w_ready;
  assign period_tick_o  = w_boundary && !nRst;
  assign pwm_o          = r_pwm;
  assign underrun_o     = r_underrun;
  assign underrun_cnt_o = r_urun_cnt;
  assign fifo_count_o   = r_count;

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_i;
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      r_cnt      <= '0;
      r_duty     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
      r_urun_cnt <= '0;
    end else begin
      r_cnt      <= enable_i ? r_cnt + 1'b1 : '0;
      r_pwm      <= enable_i && (r_cnt < r_duty);
      r_underrun <= w_under;
      if (w_under && (r_urun_cnt != 8'hFF)) begin
        r_urun_cnt <= r_urun_cnt + 8'd1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_duty   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_dac_pwm_driver.sv
// Directed bench for dac_pwm_driver: per-period high counts, FIFO
// occupancy, underrun pulses/saturation and reset behaviour.
module tb_dac_pwm_driver;

  logic       clk;
  logic       nRst;
  logic [7:0] sample_i;
  logic       sample_valid_i;
  logic       sample_ready_o;
  logic       enable_i;
  logic       pwm_o;
  logic       period_tick_o;
  logic       underrun_o;
  logic [7:0] underrun_cnt_o;
  logic [2:0] fifo_count_o;

  int vectors = 0;
  int errors  = 0;
  int tcnt    = 0;
  int hi      = 0;
  int pt      = 0;
  int ur      = 0;

  logic [7:0] tbl [5];

  dac_pwm_driver #(.N(8), .DEPTH(4)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .enable_i       (enable_i),
    .pwm_o          (pwm_o),
    .period_tick_o  (period_tick_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o),
    .fifo_count_o   (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the tick against the counter model, then advance.
  task automatic step();
    logic exp_pt;
    exp_pt = !nRst && enable_i && (tcnt == 255);
    check("period_tick", period_tick_o, exp_pt);
    pt += int'(period_tick_o);
    @(posedge clk);
    #1;
    if (nRst || !enable_i) tcnt = 0;
    else tcnt = (tcnt + 1) % 256;
    hi += int'(pwm_o);
    ur += int'(underrun_o);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'h80;
    tbl[3] = 8'hC0; tbl[4] = 8'h22;
    nRst = 1'b1; enable_i = 1'b0;
    sample_valid_i = 1'b0; sample_i = 8'h00;
    step(); step();
    check("rst_pwm", pwm_o, 0);
    check("rst_under", underrun_o, 0);
    check("rst_ucnt", underrun_cnt_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_ready", sample_ready_o, 1);
    nRst = 1'b0;

    // duty 0 for the first period, 0x40 after the first boundary
    sample_i = 8'h40; sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    check("push1_count", fifo_count_o, 1);
    enable_i = 1'b1; hi = 0; pt = 0;
    run(256);
    check("p1_high", hi, 0);
    check("p1_tick", pt, 1);
    check("p1_count", fifo_count_o, 0);
    check("p1_under", underrun_o, 0);
    hi = 0; pt = 0;
    step();
    check("p2_first", pwm_o, 1);
    run(255);
    check("p2_high", hi, 64);
    check("p2_under", underrun_o, 1);
    check("p2_ucnt", underrun_cnt_o, 1);
    enable_i = 1'b0;
    step();
    check("dis_under", underrun_o, 0);
    check("dis_pwm", pwm_o, 0);

    // five pushes while disabled: fifth dropped
    sample_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_i = tbl[i];
      step();
      check("fill_count", fifo_count_o, (i < 4) ? i + 1 : 4);
      check("fill_ready", sample_ready_o, (i < 3) ? 1 : 0);
    end

    // full FIFO, push held across a boundary
    sample_i = 8'h33;
    enable_i = 1'b1; hi = 0; pt = 0;
    run(256);
    check("full_high", hi, 64);
    check("full_pop", fifo_count_o, 3);
    check("full_ready", sample_ready_o, 1);
    hi = 0;
    step();
    sample_valid_i = 1'b0;
    check("full_repush", fifo_count_o, 4);
    pt = 0;
    run(255);
    check("d00_high", hi, 0);
    check("d00_count", fifo_count_o, 3);
    hi = 0;
    run(256);
    check("dFF_high", hi, 255);
    check("dFF_count", fifo_count_o, 2);
    hi = 0;
    run(256);
    check("d80_high", hi, 128);
    check("d80_count", fifo_count_o, 1);
    check("d3_ticks", pt, 3);

    // reset at cnt=100 with 3 queued, duty 0xC0
    sample_valid_i = 1'b1;
    sample_i = 8'h44; step();
    sample_i = 8'h55; step();
    sample_valid_i = 1'b0;
    check("q3_count", fifo_count_o, 3);
    run(98);
    check("pre_rst_pwm", pwm_o, 1);
    nRst = 1'b1; sample_valid_i = 1'b1; sample_i = 8'h00;
    check("rst_tick_comb", period_tick_o, 0);
    check("rst_ready_comb", sample_ready_o, 1);
    step();
    check("mid_rst_pwm", pwm_o, 0);
    check("mid_rst_count", fifo_count_o, 0);
    check("mid_rst_ucnt", underrun_cnt_o, 0);
    check("mid_rst_under", underrun_o, 0);
    nRst = 1'b0;
    step();
    sample_valid_i = 1'b0;
    check("resume_push", fifo_count_o, 1);
    hi = 0;
    run(255);
    check("post_rst_high", hi, 0);
    check("post_rst_count", fifo_count_o, 0);
    check("post_rst_under", underrun_o, 0);

    // underrun saturation with an empty FIFO
    hi = 0; ur = 0;
    run(256 * 255);
    check("sat_ucnt", underrun_cnt_o, 255);
    check("sat_pulses", ur, 255);
    run(256 * 4);
    check("sat_hold", underrun_cnt_o, 255);
    check("sat_pulses2", ur, 259);
    check("sat_high", hi, 0);

    // push into an empty FIFO on the boundary cycle: no bypass
    run(255);
    sample_i = 8'h20; sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    check("byp_under", underrun_o, 1);
    check("byp_count", fifo_count_o, 1);
    hi = 0;
    run(256);
    check("byp_high0", hi, 0);
    check("byp_pop", fifo_count_o, 0);
    check("byp_under2", underrun_o, 0);
    hi = 0;
    run(256);
    check("d20_high", hi, 32);
    check("d20_under", underrun_o, 1);

    // duty retained across a disable
    enable_i = 1'b0; ur = 0;
    run(3);
    check("off_pwm", pwm_o, 0);
    check("off_under", ur, 0);
    enable_i = 1'b1; hi = 0;
    run(256);
    check("ret_high", hi, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
